// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the 1-to-4 word demultiplexer.
//   DEF_WIDTH  : default data word width
//   NUM_PORTS  : number of output ports
//   port_sel_t : destination port select
//   word_t     : data word at the default width
// -----------------------------------------------------------------------------
package demux_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int NUM_PORTS = 4;

   typedef logic [1:0]           port_sel_t;
   typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/demux_port_buf.sv
// -----------------------------------------------------------------------------
// demux_port_buf
// One-entry output buffer for a single demux port. A word is loaded when the
// top-level decode selects this port. It is delivered when out_valid and
// out_ready are both high. A load in the same cycle as a delivery keeps the
// buffer full with the new word, so each port sustains one word per cycle.
// Optional macro DEMUX_STATS_EN adds a saturating delivered-word counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : accept the word on load_data into this buffer
//   load_data   : incoming word
//   ready       : buffer can take a word this cycle (empty or draining)
//   out_valid   : buffer holds a word
//   out_ready   : consumer takes the word
//   out_data    : buffered word, keeps its last value after delivery
//   stat_clr    : synchronous counter clear (ignored without DEMUX_STATS_EN)
//   stat_cnt    : delivered-word count (constant 0 without DEMUX_STATS_EN)
// -----------------------------------------------------------------------------
module demux_port_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic             ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_cnt
);

   logic             vld_p1;
   logic [WIDTH-1:0] data_p1;
   logic             deliver;

   assign deliver   = vld_p1 && out_ready;
   assign ready     = !vld_p1 || out_ready;
   assign out_valid = vld_p1;
   assign out_data  = data_p1;

   // Stage p1: buffer register, one cycle after acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= load_data;
         end else if (deliver) begin
            vld_p1  <= 1'b0;
         end
      end
   end

`ifdef DEMUX_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [CNT_W-1:0] cnt_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1 <= '0;
      end else if (stat_clr) begin
         cnt_p1 <= '0;
      end else if (deliver) begin
         cnt_p1 <= sat_inc(cnt_p1);
      end
   end

   assign stat_cnt = cnt_p1;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_cnt        = '0;
`endif

endmodule

// File: rtl/demux_1to4.sv
// -----------------------------------------------------------------------------
// demux_1to4
// Registered 1-to-4 word demultiplexer. One word per cycle enters on a
// valid/ready handshake and is steered by in_sel into that port's one-entry
// buffer. Ports are independent: a stalled port never blocks the others.
// Optional macro DEMUX_STATS_EN enables per-port delivered-word counters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : producer presents a word
//   in_ready   : the port named by in_sel can take a word
//   in_data    : incoming word
//   in_sel     : destination port 0..3
//   out_valid  : bit k set while port k holds a word
//   out_ready  : bit k set when port k consumer takes its word
//   out_data   : port k word at [k*WIDTH +: WIDTH]
//   stat_clr   : synchronous clear of all counters
//   stat_cnt   : port k delivered count at [k*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module demux_1to4
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  port_sel_t                  in_sel,
   output logic [NUM_PORTS-1:0]       out_valid,
   input  logic [NUM_PORTS-1:0]       out_ready,
   output logic [NUM_PORTS*WIDTH-1:0] out_data,
   input  logic                       stat_clr,
   output logic [NUM_PORTS*CNT_W-1:0] stat_cnt
);

   logic [NUM_PORTS-1:0] port_ready;
   logic [NUM_PORTS-1:0] port_load;
   logic                 accept_p0;

   // Stage p0: combinational accept; only the selected port's readiness counts
   assign in_ready  = port_ready[in_sel];
   assign accept_p0 = in_valid && in_ready;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      assign port_load[k] = accept_p0 && (in_sel == port_sel_t'(k));

      demux_port_buf #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_buf (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (port_load[k]),
         .load_data (in_data),
         .ready     (port_ready[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_data  (out_data[k*WIDTH +: WIDTH]),
         .stat_clr  (stat_clr),
         .stat_cnt  (stat_cnt[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_demux_1to4.sv
module tb_demux_1to4;
   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [4*WIDTH-1:0] out_data;
   logic               stat_clr;
   logic [4*CNT_W-1:0] stat_cnt;

   int checks = 0;
   int errors = 0;

   demux_1to4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stat_clr  (stat_clr),
      .stat_cnt  (stat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0;
      out_ready = 4'b0000; stat_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++; if (stat_cnt !== '0) begin errors++; $display("FAIL reset_stat_cnt: got %h expected 0", stat_cnt); end
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s); #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready sel%0d: got %b expected 1", s, in_ready); end
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hDEADBEEF; in_sel = 2'd2; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_out_valid: got %b expected 0100", out_valid); end
      checks++; if (out_data[2*WIDTH +: WIDTH] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", out_data[2*WIDTH +: WIDTH]); end
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h12345678; in_sel = 2'd2; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_full_ready: got %b expected 0", in_ready); end
      in_sel = 2'd0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_other_ready: got %b expected 1", in_ready); end
      in_valid = 1'b0;
      out_ready = 4'b0100; #1;
      in_sel = 2'd2; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_drain_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drained: got %b expected 0000", out_valid); end
      checks++; if (out_data[2*WIDTH +: WIDTH] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_retain: got %h expected deadbeef", out_data[2*WIDTH +: WIDTH]); end
      out_ready = 4'b0000;
   endtask

   task automatic test_back_to_back();
      out_ready = 4'b0010;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_sel = 2'd1; in_data = 32'(i); #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready word%0d: got %b expected 1", i, in_ready); end
         @(posedge clk); #1;
         checks++;
         if (out_valid[1] !== 1'b1 || out_data[WIDTH +: WIDTH] !== 32'(i)) begin
            errors++; $display("FAIL b2b_word%0d: got valid %b data %h expected valid 1 data %h", i, out_valid[1], out_data[WIDTH +: WIDTH], 32'(i));
         end
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_empty: got %b expected 0000", out_valid); end
      out_ready = 4'b0000;
   endtask

   task automatic test_isolation();
      @(negedge clk);
      in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h33333333;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL iso_fill: got %b expected 1000", out_valid); end
      out_ready = 4'b0111;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         in_valid = 1'b1; in_sel = 2'(j % 3); in_data = 32'hA0 + 32'(j); #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL iso_ready word%0d: got %b expected 1", j, in_ready); end
         @(posedge clk); #1;
         checks++;
         if (out_valid[j % 3] !== 1'b1 || out_data[(j % 3)*WIDTH +: WIDTH] !== 32'hA0 + 32'(j)) begin
            errors++; $display("FAIL iso_word%0d: got valid %b data %h expected valid 1 data %h", j, out_valid[j % 3], out_data[(j % 3)*WIDTH +: WIDTH], 32'hA0 + 32'(j));
         end
         checks++;
         if (out_valid[3] !== 1'b1 || out_data[3*WIDTH +: WIDTH] !== 32'h33333333) begin
            errors++; $display("FAIL iso_port3 word%0d: got valid %b data %h expected valid 1 data 33333333", j, out_valid[3], out_data[3*WIDTH +: WIDTH]);
         end
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL iso_final: got %b expected 1000", out_valid); end
      out_ready = 4'b0000;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h11;
      @(negedge clk);
      in_sel = 2'd1; in_data = 32'h22;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b1011) begin errors++; $display("FAIL mid_full: got %b expected 1011", out_valid); end
      out_ready = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_async_valid: got %b expected 0000", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_async_data: got %h expected 0", out_data); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_after_release: got %b expected 0000", out_valid); end
      checks++; if (stat_cnt !== '0) begin errors++; $display("FAIL mid_stat_cnt: got %h expected 0", stat_cnt); end
      out_ready = 4'b0000;
   endtask

   task automatic test_stats();
      out_ready = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h100 + 32'(i);
         if (i == 4) begin
            // three words delivered so far (words 0..2)
`ifdef DEMUX_STATS_EN
            checks++; if (stat_cnt !== 16'h0003) begin errors++; $display("FAIL stats_partial: got %h expected 0003", stat_cnt); end
`else
            checks++; if (stat_cnt !== 16'h0000) begin errors++; $display("FAIL stats_off_partial: got %h expected 0000", stat_cnt); end
`endif
         end
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
`ifdef DEMUX_STATS_EN
      checks++; if (stat_cnt !== 16'h000F) begin errors++; $display("FAIL stats_saturate: got %h expected 000f", stat_cnt); end
`else
      checks++; if (stat_cnt !== 16'h0000) begin errors++; $display("FAIL stats_off_count: got %h expected 0000", stat_cnt); end
`endif
      @(negedge clk);
      out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h55;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 4'b0001; stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      checks++; if (stat_cnt !== 16'h0000) begin errors++; $display("FAIL stats_clr_wins: got %h expected 0000", stat_cnt); end
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stats_clr_delivered: got %b expected 0000", out_valid); end
      out_ready = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_isolation();
      test_reset_mid();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
